// File: rtl/audio_dac_tx.sv
// audio_dac_tx
// I2S transmitter fed by wave_gen. It fetches one 16-bit sample per audio
// frame through a req_next/aud_done handshake and buffers it. It sends the
// sample MSB first on both the left and right slots, and derives BCLK and
// LRCK from clk.
//
// Ports:
//   clk       in  system clock
//   reset     in  asynchronous, active-high reset
//   aud_data  in  16-bit signed sample from wave_gen
//   aud_done  in  aud_data valid (level)
//   req_next  out one-cycle pulse requesting the next sample
//   dac_bclk  out codec bit clock (BCLK_HALF clk per half period)
//   dac_lrck  out codec LR clock, 0 = left slot, 1 = right slot
//   dac_dat   out serial data, I2S one-bit delay after the LRCK edge
//   underrun  out sticky flag, a frame started with no new sample
module audio_dac_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] aud_data,
  input  logic        aud_done,
  output logic        req_next,
  output logic        dac_bclk,
  output logic        dac_lrck,
  output logic        dac_dat,
  output logic        underrun
);

  localparam int DIV_W = $clog2(BCLK_HALF);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ARM  = 2'd2,
    ST_WAIT = 2'd3
  } fetch_state_e;

  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic             lrck_r;
  logic             dat_r;
  logic [15:0]      pending_r;
  logic             pending_valid_r;
  logic [15:0]      frame_reg_r;
  logic             underrun_r;
  logic             req_next_r;
  fetch_state_e     state_r;

  logic             bclk_fall_s;
  logic             frame_start_s;
  logic             capture_s;
  logic [BIT_W-1:0] bit_nxt_s;
  logic [BIT_W-1:0] slot_bit_s;
  logic [3:0]       dat_idx_s;
  logic             dat_nxt_s;

  // Decode BCLK falling edge, frame start, capture and the next serial bit.
  always_comb begin
    bclk_fall_s   = (div_cnt_r == DIV_LAST) && bclk_r;
    frame_start_s = bclk_fall_s && (bit_cnt_r == BIT_LAST);
    capture_s     = (state_r == ST_WAIT) && aud_done;
    if (bit_cnt_r == BIT_LAST) begin
      bit_nxt_s = {BIT_W{1'b0}};
    end else begin
      bit_nxt_s = bit_cnt_r + BIT_W'(1);
    end
    if (bit_nxt_s >= SLOT_LEN) begin
      slot_bit_s = bit_nxt_s - SLOT_LEN;
    end else begin
      slot_bit_s = bit_nxt_s;
    end
    // Slot bit 1 carries bit 15; slot bit 0 is the I2S delay bit.
    dat_idx_s = 4'(BIT_W'(16) - slot_bit_s);
    if ((slot_bit_s >= BIT_W'(1)) && (slot_bit_s <= BIT_W'(16))) begin
      dat_nxt_s = frame_reg_r[dat_idx_s];
    end else begin
      dat_nxt_s = 1'b0;
    end
  end

  // BCLK divider and frame bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= 1'b0;
      bit_cnt_r <= {BIT_W{1'b0}};
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      if (bclk_fall_s) begin
        bit_cnt_r <= bit_nxt_s;
      end
    end
  end

  // LRCK and serial data change together with the BCLK falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrck_r <= 1'b0;
      dat_r  <= 1'b0;
    end else if (bclk_fall_s) begin
      lrck_r <= (bit_nxt_s >= SLOT_LEN);
      dat_r  <= dat_nxt_s;
    end
  end

  // Sample buffer: pending slot, serializer word and sticky underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r       <= 16'h0000;
      pending_valid_r <= 1'b0;
      frame_reg_r     <= 16'h0000;
      underrun_r      <= 1'b0;
    end else if (frame_start_s) begin
      if (pending_valid_r) begin
        frame_reg_r     <= pending_r;
        pending_valid_r <= 1'b0;
      end else if (capture_s) begin
        // Sample arrived exactly at frame start: skip the pending slot.
        frame_reg_r <= aud_data;
      end else begin
        underrun_r <= 1'b1;
      end
    end else if (capture_s) begin
      pending_r       <= aud_data;
      pending_valid_r <= 1'b1;
    end
  end

  // Fetch FSM; ARM blanks a done left over from the previous request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      req_next_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!pending_valid_r) begin
            state_r    <= ST_REQ;
            req_next_r <= 1'b1;
          end else begin
            req_next_r <= 1'b0;
          end
        end
        ST_REQ: begin
          state_r    <= ST_ARM;
          req_next_r <= 1'b0;
        end
        ST_ARM: begin
          state_r    <= ST_WAIT;
          req_next_r <= 1'b0;
        end
        ST_WAIT: begin
          req_next_r <= 1'b0;
          if (aud_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          req_next_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_next = req_next_r;
  assign dac_bclk = bclk_r;
  assign dac_lrck = lrck_r;
  assign dac_dat  = dat_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Randomized bench for audio_dac_tx with default parameters. A responder
// answers each req_next after a per-request latency taken from a table.
// A frame-level model predicts each decoded frame and the req_next cycle.
// It also predicts the underrun flag. Frame starts fall every 1024 clk
// counted from reset release. Each frame start consumes the oldest sample
// captured at or before that edge; otherwise the previous word repeats.
module tb_audio_dac_tx;
  localparam int          FRAME_CLK = 1024;
  localparam int          N_TAB     = 32;
  localparam logic [15:0] JUNK      = 16'hDEAD;

  logic        clk;
  logic        reset;
  logic [15:0] aud_data;
  logic        aud_done;
  logic        req_next;
  logic        dac_bclk;
  logic        dac_lrck;
  logic        dac_dat;
  logic        underrun;

  audio_dac_tx dut (
    .clk      (clk),
    .reset    (reset),
    .aud_data (aud_data),
    .aud_done (aud_done),
    .req_next (req_next),
    .dac_bclk (dac_bclk),
    .dac_lrck (dac_lrck),
    .dac_dat  (dac_dat),
    .underrun (underrun)
  );

  typedef struct packed {
    int unsigned cap_edge;
    logic [15:0] data;
  } cap_t;

  int          checks;
  int          failures;
  int unsigned e;
  logic [15:0] data_tab [N_TAB];
  int          lat_tab  [N_TAB];
  logic        mid_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of rising clk edges since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) e <= 0;
    else       e <= e + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_sample();
    logic [15:0] d;
    d = 16'($urandom);
    if (d == JUNK) d = d ^ 16'h0001;
    return d;
  endfunction

  task automatic wait_edge(input int unsigned target);
    int budget;
    budget = 25000;
    while (e < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("wait_edge", e, target);
  endtask

  // Responder, stream decoder and frame-level reference model.
  initial begin : monitor
    cap_t        cap_q[$];
    cap_t        c;
    logic        bits [0:63];
    logic        lrb  [0:63];
    int          pos;
    logic        prev_bclk;
    logic        prev_lrck;
    logic [15:0] cur_exp;
    logic        exp_underrun;
    int unsigned exp_req_e;
    logic        resp_busy;
    int          resp_cnt;
    int          resp_idx;
    logic [15:0] resp_data;
    logic [15:0] left;
    logic [15:0] right;
    logic        pad;
    int          lr_bad;
    int          lat;

    aud_done = 1'b0;
    aud_data = 16'h0000;
    resp_idx = 0;
    resp_busy = 1'b0;
    resp_cnt = 0;
    resp_data = 16'h0000;
    pos = 0;
    prev_bclk = 1'b0;
    prev_lrck = 1'b0;
    cur_exp = 16'h0000;
    exp_underrun = 1'b0;
    exp_req_e = 1;
    forever begin
      @(negedge clk);
      if (reset) begin
        // A request in flight when reset hits gets a stale done during reset.
        if (resp_busy) begin
          aud_done = 1'b1;
          aud_data = JUNK;
        end else begin
          aud_done = 1'b0;
        end
        resp_busy = 1'b0;
        cap_q.delete();
        pos = 0;
        cur_exp = 16'h0000;
        exp_underrun = 1'b0;
        exp_req_e = 1;
      end else begin
        aud_done = 1'b0;
        if (dac_bclk && !prev_bclk) begin
          if (e < 2100) check_eq("bclk_rise_phase", e % 16, 32'd8);
          if (pos < 64) begin
            bits[pos] = dac_dat;
            lrb[pos]  = dac_lrck;
          end
          pos++;
        end
        if (!dac_bclk && prev_bclk && e < 2100) check_eq("bclk_fall_phase", e % 16, 32'd0);
        if (dac_lrck && !prev_lrck) check_eq("lrck_rise_phase", e % FRAME_CLK, 32'd512);
        if (!dac_lrck && prev_lrck) check_eq("lrck_fall_phase", e % FRAME_CLK, 32'd0);

        if (e != 0 && (e % FRAME_CLK) == 0) begin
          check_eq("frame_bits", pos, 32'd64);
          left = 16'h0000;
          right = 16'h0000;
          pad = 1'b0;
          lr_bad = 0;
          for (int i = 0; i < 64; i++) begin
            if (i >= 1 && i <= 16)       left[16 - i]  = bits[i];
            else if (i >= 33 && i <= 48) right[48 - i] = bits[i];
            else                         pad = pad | bits[i];
            if (lrb[i] != (i >= 32)) lr_bad++;
          end
          check_eq("frame_left", 32'(left), 32'(cur_exp));
          check_eq("frame_right", 32'(right), 32'(cur_exp));
          check_eq("frame_pad", 32'(pad), 32'd0);
          check_eq("frame_lrck", lr_bad, 32'd0);
          if (mid_done) check_eq("stale_sample", 32'(left == JUNK), 32'd0);
          if (cap_q.size() > 0 && cap_q[0].cap_edge <= e) begin
            cur_exp = cap_q[0].data;
            void'(cap_q.pop_front());
            exp_req_e = e + 1;
          end else begin
            exp_underrun = 1'b1;
          end
          check_eq("underrun", 32'(underrun), 32'(exp_underrun));
          pos = 0;
        end

        if (req_next || e == exp_req_e)
          check_eq("req_next_edge", req_next ? e : 32'hFFFF_FFFF, exp_req_e);

        if (resp_busy) begin
          if (resp_cnt == 0) begin
            aud_done = 1'b1;
            aud_data = resp_data;
            c.cap_edge = e + 1;
            c.data = resp_data;
            cap_q.push_back(c);
            resp_busy = 1'b0;
          end else begin
            resp_cnt--;
          end
        end else if (req_next) begin
          if (resp_idx < N_TAB) begin
            resp_data = data_tab[resp_idx];
            lat = lat_tab[resp_idx];
          end else begin
            resp_data = rand_sample();
            lat = 5;
          end
          resp_idx++;
          resp_busy = 1'b1;
          resp_cnt = lat - 1;
        end
      end
      prev_bclk = dac_bclk;
      prev_lrck = dac_lrck;
    end
  end

  initial begin : stimulus
    checks = 0;
    failures = 0;
    mid_done = 1'b0;
    for (int i = 0; i < N_TAB; i++) begin
      data_tab[i] = rand_sample();
      lat_tab[i]  = int'($urandom_range(1000, 2));
    end
    data_tab[0] = 16'hA5C3;
    lat_tab[0]  = 5;
    for (int i = 1; i <= 10; i++) begin
      data_tab[i] = 16'(i);
      lat_tab[i]  = 5;
    end
    lat_tab[11] = 1022;  // done first seen in the frame-start cycle
    lat_tab[15] = 1500;  // misses one frame start
    lat_tab[17] = 900;   // still outstanding when reset hits at bit 40

    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1 check_eq("reset_outputs", 32'({req_next, dac_bclk, dac_lrck, dac_dat, underrun}), 32'd0);
    end
    #1 reset = 1'b0;

    wait_edge(18 * FRAME_CLK + 650);
    #2 reset = 1'b1;
    mid_done = 1'b1;
    #1 check_eq("reset_mid_outputs", 32'({req_next, dac_bclk, dac_lrck, dac_dat, underrun}), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 check_eq("reset_hold_outputs", 32'({req_next, dac_bclk, dac_lrck, dac_dat, underrun}), 32'd0);
    end
    #1 reset = 1'b0;

    wait_edge(4 * FRAME_CLK + 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_dac_tx.md
# audio_dac_tx

Serial audio transmitter that sits directly downstream of `wave_gen`. It fetches one 16-bit sample per audio frame using the `req_next` / `aud_done` handshake and buffers it. It then serializes the sample in I2S format to the board codec DAC, with the same sample on the left and right channels. It generates the codec bit clock and LR clock from the system clock and flags underruns when the generator is late.

## Interface
Parameters:
- `BCLK_HALF`, default 8: clk cycles per BCLK half-period; must be ≥2.
- `SLOT_BITS`, default 32: BCLK periods per channel slot; must be ≥17.

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `aud_data` in 16: signed sample from `wave_gen`.
- `aud_done` in 1: `aud_data` is valid (level).
- `req_next` out 1: one-cycle pulse that requests the next sample.
- `dac_bclk` out 1: codec bit clock.
- `dac_lrck` out 1: codec LR clock; 0 = left slot, 1 = right slot.
- `dac_dat` out 1: serial data, MSB first.
- `underrun` out 1: sticky flag, set when a frame starts with no new sample.

## Operation
- Clock divider:
  - `div_cnt` counts 0..`BCLK_HALF`-1.
  - At the terminal count, `dac_bclk` toggles and `div_cnt` returns to 0.
- Bit counter:
  - `bit_cnt` counts 0..2·`SLOT_BITS`-1.
  - It advances on every BCLK falling-edge cycle (the clk cycle in which `dac_bclk` goes 1→0).
  - It wraps to 0; the wrap is the frame start.
- Slot outputs, with slot bit b = `bit_cnt` mod `SLOT_BITS`:
  - `dac_lrck` = (`bit_cnt` ≥ `SLOT_BITS`).
  - `dac_dat` = `frame_reg`[16-b] for 1≤b≤16, else 0 (I2S one-bit delay).
  - `dac_lrck` and `dac_dat` are registered and update in the same cycle as the BCLK falling edge.
  - The codec samples on the BCLK rising edge.
- Sample buffering: `pending` (16 bits) plus `pending_valid`, and `frame_reg` (16 bits), which feeds the serializer.
- Fetch FSM:
  - IDLE: if `pending_valid`=0, go to REQ.
  - REQ: `req_next`=1 for this one cycle, then go to ARM.
  - ARM: `aud_done` is ignored (blanking for a stale done), then go to WAIT.
  - WAIT: on the first cycle with `aud_done`=1, capture `aud_data` into `pending`, set `pending_valid`, and go to IDLE.
  - `aud_done` is ignored in IDLE, REQ and ARM.
- At frame start:
  - If `pending_valid`: `frame_reg`←`pending` and `pending_valid`←0.
  - Otherwise: `frame_reg` holds its previous value (the sample repeats) and `underrun`←1. No extra request is issued; the outstanding request stays in WAIT.
- Simultaneous frame start and WAIT capture: `aud_data` bypasses `pending` straight into `frame_reg`. `pending_valid` stays 0 and `underrun` is not set. The FSM then goes IDLE→REQ.
- At most one request is outstanding; at most one sample is buffered.
- `underrun` clears only on `reset`.

## Timing
- Reset values: `div_cnt`=0, `bit_cnt`=0, `frame_reg`=0, `pending_valid`=0, FSM=IDLE, and all outputs 0.
- Reset is asynchronous, so it is valid mid-frame and mid-handshake. An `aud_done` during reset is discarded.
- The frame at `bit_cnt`=0 after reset outputs silence (`frame_reg`=0).
- With the defaults:
  - BCLK period = 16 clk.
  - Frame = 64 BCLK = 1024 clk (48.83 kHz).
  - `dac_lrck` high for 512 clk.
- `req_next` timing:
  - The first `req_next` is high for exactly one cycle, starting at the first rising clk edge after `reset` falls.
  - After a consuming frame start, `req_next` rises 2 cycles later (frame start clears `pending_valid`; IDLE→REQ on the next edge).
- Capture latency: `aud_done` must be observed no earlier than 2 cycles after the `req_next` cycle. The capture completes at the edge where `aud_done` is first seen in WAIT.
- A sample is transmitted in the frame following its capture, or in the same frame if captured in the frame-start cycle.

## Test plan
- **Reset and clocks:** release reset with a responder model idle. Require all outputs 0 during reset, `req_next` high for 1 cycle at the first edge, BCLK period 16 clk, and LRCK period 1024 clk.
- **Serialization:** the responder asserts `aud_done` with `aud_data`=16'hA5C3 five cycles after `req_next`. In the next frame, require:
  - left slot bits 1..16 = A5C3 MSB first on BCLK rising edges, with bit 0 and bits 17..31 = 0;
  - right slot identical;
  - `underrun`=0.
- **Streaming:** the responder returns 16'h0001, 0002, … with 5-cycle latency. Over 10 frames, require:
  - each frame carries the next value;
  - exactly one `req_next` per frame, 2 cycles after frame start;
  - `underrun`=0.
- **Underrun:** delay one response by 1500 cycles. Require:
  - that frame repeats the previous sample;
  - `underrun`=1 from that frame start and held;
  - no extra `req_next`;
  - the late sample is transmitted in the following frame.
- **Coincident capture:** time `aud_done` to be first seen in the frame-start cycle. Require that sample to be serialized in that same frame, `underrun`=0, and `req_next` 2 cycles later.
- **Reset mid-frame:** assert `reset` at `bit_cnt`=40 while in WAIT, and pulse `aud_done` during reset. Require:
  - outputs 0 immediately;
  - after release, one `req_next` at the first edge;
  - the discarded sample is never transmitted.
